fifo_fwft: RTL and testbench

- Parametrised successor to the team's small 8-bit/4-entry FIFO: configurable width and power-of-two depth, all DEPTH entries usable, first-word-fall-through read.
- Adds fill-level output, almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.
- Sits between the USB byte-stream producers and the processing/consumer logic as the general-purpose buffer in the process path.

---
 rtl/fifo_fwft.sv | 104 ++++++++++
 tb/tb_fifo_fwft.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO with parameterised width and power-of-two depth.
// All entries are usable (wrap-bit pointers); it provides level, thresholds, flush and sticky error flags.
module fifo_fwft #(
  parameter int FIFO_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int AFULL_LEVEL  = FIFO_DEPTH - 1,
  parameter int AEMPTY_LEVEL = 1,
  localparam int ADDR_W      = $clog2(FIFO_DEPTH),
  localparam int LVL_W       = ADDR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  data_in_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  input  logic                  data_out_en,
  input  logic                  flush,
  input  logic                  err_clr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [LVL_W-1:0]      level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [LVL_W:0] AFULL_C  = AFULL_LEVEL[LVL_W:0];
  localparam logic [LVL_W:0] AEMPTY_C = AEMPTY_LEVEL[LVL_W:0];

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [LVL_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [LVL_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;
  logic             written_reg, written_next;

  logic wr_accept;
  logic rd_accept;

  // Status is derived only from registered pointers, so there is no path from the enables.
  assign full  = (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]) &&
                 (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign level = wr_ptr_reg - rd_ptr_reg;

  assign almost_full  = ({1'b0, level} >= AFULL_C);
  assign almost_empty = ({1'b0, level} <= AEMPTY_C);

  assign wr_accept = data_in_en & ~full & ~flush;
  assign rd_accept = data_out_en & ~empty & ~flush;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    written_next   = written_reg | wr_accept;

    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (wr_accept) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (rd_accept) rd_ptr_next = rd_ptr_reg + 1'b1;
    end

    // A new error event in the same cycle as err_clr keeps the flag set.
    if (data_in_en & full & ~flush) overflow_next = 1'b1;
    else if (err_clr)               overflow_next = 1'b0;

    if (data_out_en & empty & ~flush) underflow_next = 1'b1;
    else if (err_clr)                 underflow_next = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      written_reg   <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
      written_reg   <= written_next;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_reg[ADDR_W-1:0]] <= data_in;
  end

  // The head word is forced to zero until the first write after reset, so unwritten storage never shows.
  assign data_out = written_reg ? mem[rd_ptr_reg[ADDR_W-1:0]] : '0;

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_fifo_fwft.sv
// Directed self-checking bench for fifo_fwft: default 8x4 instance plus a 16x16 instance.
module tb_fifo_fwft;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit x 4 instance
  logic [7:0] a_din, a_dout;
  logic       a_wen, a_ren, a_flush, a_clr;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic [2:0] a_level;

  // 16-bit x 16 instance
  logic [15:0] b_din, b_dout;
  logic        b_wen, b_ren, b_flush, b_clr;
  logic        b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [4:0]  b_level;

  int checks = 0;
  int errors = 0;

  fifo_fwft u_dut_a (
    .clk(clk), .rst(rst), .data_in(a_din), .data_in_en(a_wen), .data_out(a_dout),
    .data_out_en(a_ren), .flush(a_flush), .err_clr(a_clr), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .level(a_level), .overflow(a_ovf), .underflow(a_udf)
  );

  fifo_fwft #(.FIFO_WIDTH(16), .FIFO_DEPTH(16)) u_dut_b (
    .clk(clk), .rst(rst), .data_in(b_din), .data_in_en(b_wen), .data_out(b_dout),
    .data_out_en(b_ren), .flush(b_flush), .err_clr(b_clr), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .level(b_level), .overflow(b_ovf), .underflow(b_udf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("check %s: %0h ok", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] seq [4];

  initial begin
    seq[0] = 8'hA1; seq[1] = 8'hB2; seq[2] = 8'hC3; seq[3] = 8'hD4;
    a_din = '0; a_wen = 0; a_ren = 0; a_flush = 0; a_clr = 0;
    b_din = '0; b_wen = 0; b_ren = 0; b_flush = 0; b_clr = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_level", 32'(a_level), 0);
    check("rst_empty", 32'(a_empty), 1);
    check("rst_full", 32'(a_full), 0);
    check("rst_ae", 32'(a_ae), 1);
    check("rst_af", 32'(a_af), 0);
    check("rst_ovf", 32'(a_ovf), 0);
    check("rst_udf", 32'(a_udf), 0);
    check("rst_dout", 32'(a_dout), 0);

    // Fill: level 1..4, almost_full from level 3, full at 4
    for (int i = 0; i < 4; i++) begin
      a_wen = 1; a_din = seq[i];
      tick();
      check($sformatf("fill_level%0d", i), 32'(a_level), 32'(i + 1));
      check($sformatf("fill_dout%0d", i), 32'(a_dout), 32'hA1);
      check($sformatf("fill_af%0d", i), 32'(a_af), (i >= 2) ? 1 : 0);
      check($sformatf("fill_full%0d", i), 32'(a_full), (i == 3) ? 1 : 0);
    end

    // Write while full
    a_din = 8'hEE;
    tick();
    check("ovf_level", 32'(a_level), 4);
    check("ovf_flag", 32'(a_ovf), 1);
    a_wen = 0;

    // Drain in order
    a_ren = 1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_dout%0d", i), 32'(a_dout), 32'(seq[i]));
      tick();
    end
    check("drain_empty", 32'(a_empty), 1);
    check("drain_udf_clear", 32'(a_udf), 0);
    tick();
    check("udf_flag", 32'(a_udf), 1);
    check("udf_ovf_held", 32'(a_ovf), 1);
    a_ren = 0; a_clr = 1;
    tick();
    a_clr = 0;
    check("clr_ovf", 32'(a_ovf), 0);
    check("clr_udf", 32'(a_udf), 0);

    // Streaming, 40 words, one in flight
    a_wen = 1; a_din = 8'd0;
    tick();
    check("stream_first_level", 32'(a_level), 1);
    a_ren = 1;
    for (int k = 1; k < 40; k++) begin
      check($sformatf("stream_dout%0d", k - 1), 32'(a_dout), 32'(k - 1));
      a_din = 8'(k);
      tick();
      check($sformatf("stream_level%0d", k), 32'(a_level), 1);
    end
    check("stream_dout39", 32'(a_dout), 39);
    a_wen = 0;
    tick();
    a_ren = 0;
    check("stream_end_empty", 32'(a_empty), 1);
    check("stream_ovf", 32'(a_ovf), 0);
    check("stream_udf", 32'(a_udf), 0);

    // Simultaneous read/write while full
    a_wen = 1;
    for (int i = 0; i < 4; i++) begin
      a_din = 8'(8'h10 + i);
      tick();
    end
    check("sim_full", 32'(a_full), 1);
    a_din = 8'h55; a_ren = 1;
    tick();
    a_wen = 0;
    check("simfull_level", 32'(a_level), 3);
    check("simfull_ovf", 32'(a_ovf), 1);
    for (int i = 1; i < 4; i++) begin
      check($sformatf("simfull_dout%0d", i), 32'(a_dout), 32'(8'h10 + i));
      tick();
    end
    a_ren = 0; a_clr = 1;
    tick();
    a_clr = 0;
    check("simfull_drained", 32'(a_empty), 1);

    // Simultaneous read/write while empty
    a_wen = 1; a_ren = 1; a_din = 8'h66;
    tick();
    a_wen = 0; a_ren = 0;
    check("simempty_level", 32'(a_level), 1);
    check("simempty_dout", 32'(a_dout), 32'h66);
    check("simempty_udf", 32'(a_udf), 1);
    check("simempty_ovf", 32'(a_ovf), 0);
    a_ren = 1;
    tick();
    a_ren = 0;

    // Flush with concurrent write; underflow stays set
    a_wen = 1;
    for (int i = 0; i < 3; i++) begin
      a_din = 8'(8'h21 + i);
      tick();
    end
    check("preflush_level", 32'(a_level), 3);
    a_din = 8'h77; a_flush = 1;
    tick();
    a_wen = 0; a_flush = 0;
    check("flush_level", 32'(a_level), 0);
    check("flush_empty", 32'(a_empty), 1);
    check("flush_udf_kept", 32'(a_udf), 1);
    check("flush_ovf_kept", 32'(a_ovf), 0);
    tick();
    check("flush_write_dropped", 32'(a_level), 0);

    // Asynchronous reset between edges with 2 words stored
    a_wen = 1;
    a_din = 8'h31; tick();
    a_din = 8'h32; tick();
    a_wen = 0;
    check("prerst_level", 32'(a_level), 2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_level", 32'(a_level), 0);
    check("arst_empty", 32'(a_empty), 1);
    check("arst_udf", 32'(a_udf), 0);
    check("arst_ovf", 32'(a_ovf), 0);
    check("arst_dout", 32'(a_dout), 0);
    #1 rst = 1'b0;
    a_wen = 1; a_din = 8'h41;
    tick();
    a_wen = 0;
    check("postrst_level", 32'(a_level), 1);
    check("postrst_dout", 32'(a_dout), 32'h41);

    // Wide/deep instance
    b_wen = 1;
    for (int i = 0; i < 16; i++) begin
      b_din = 16'(16'hA000 + i * 16'h0111);
      tick();
    end
    b_wen = 0;
    check("b_full", 32'(b_full), 1);
    check("b_level", 32'(b_level), 16);
    check("b_af", 32'(b_af), 1);
    b_ren = 1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("b_dout%0d", i), 32'(b_dout), 32'(16'hA000 + i * 16'h0111));
      tick();
    end
    b_ren = 0;
    check("b_empty", 32'(b_empty), 1);
    check("b_udf", 32'(b_udf), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
